// File: rtl/camera_stream_gen_if.sv
// Pixel-word stream into the camera timing generator: 32-bit words with a
// valid/ready handshake. The source drives data and valid, the generator
// drives ready.
interface camera_stream_gen_if;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/camera_stream_gen.sv
// Camera-style parallel video generator. Emits vsync / href / 8-bit data
// timing for a DVP-like sensor bus from a stream of 32-bit pixel words.
// Bytes leave MSB first through a one-word holding buffer; an empty buffer
// at the start of a word slot yields four zero bytes and a sticky underrun.
module camera_stream_gen #(
    parameter int H_ACTIVE    = 1280,
    parameter int H_BLANK     = 160,
    parameter int V_ACTIVE    = 480,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 2,
    parameter int V_FRONT     = 2
) (
    input  logic                camera_pclk,
    input  logic                rst_n,
    input  logic                enable,
    camera_stream_gen_if.slave  s,
    output logic                camera_vsync,
    output logic                camera_href,
    output logic [7:0]          camera_data,
    output logic                frame_start,
    output logic                underrun
);

    localparam int LINE_LEN  = H_ACTIVE + H_BLANK;
    localparam int CNT_W     = $clog2(LINE_LEN);
    localparam int MAX_A     = (VSYNC_LINES > V_BACK) ? VSYNC_LINES : V_BACK;
    localparam int MAX_B     = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
    localparam int MAX_LINES = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int LINE_W    = $clog2(MAX_LINES + 1);

    localparam logic [CNT_W-1:0]  LAST_CNT   = CNT_W'(LINE_LEN - 1);
    localparam logic [CNT_W-1:0]  LAST_ACT   = CNT_W'(H_ACTIVE - 1);
    localparam logic [LINE_W-1:0] LAST_VSYNC = LINE_W'(VSYNC_LINES - 1);
    localparam logic [LINE_W-1:0] LAST_VBACK = LINE_W'(V_BACK - 1);
    localparam logic [LINE_W-1:0] LAST_VACT  = LINE_W'(V_ACTIVE - 1);
    localparam logic [LINE_W-1:0] LAST_VFRT  = LINE_W'(V_FRONT - 1);

    typedef enum logic [2:0] {IDLE, VSYNC, VBACK, ACTIVE, HBLANK, VFRONT} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic [31:0]       buf_q, buf_d;
    logic              buf_valid_q, buf_valid_d;
    logic              skip_q, skip_d;
    logic              vsync_q, vsync_d;
    logic              href_q, href_d;
    logic [7:0]        data_q, data_d;
    logic              fs_q, fs_d;
    logic              ur_q, ur_d;
    logic              s_ready_q, s_ready_d;
    logic              eol, frame_done;
    logic              accept, word_free, word_start;
    logic [1:0]        idx_q, idx_d;

    // Frame timing: state, cycle-in-line counter and line counter.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case can leave one unassigned and infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q + 1'b1;
        line_d     = line_q;
        fs_d       = 1'b0;
        frame_done = 1'b0;
        eol        = (cnt_q == LAST_CNT);
        unique case (state_q)
            IDLE: begin
                cnt_d  = '0;
                line_d = '0;
                if (enable) begin
                    state_d = VSYNC;
                    fs_d    = 1'b1;
                end
            end
            VSYNC: if (eol) begin
                cnt_d = '0;
                if (line_q == LAST_VSYNC) begin
                    line_d  = '0;
                    state_d = (V_BACK == 0) ? ACTIVE : VBACK;
                end else begin
                    line_d = line_q + 1'b1;
                end
            end
            VBACK: if (eol) begin
                cnt_d = '0;
                if (line_q == LAST_VBACK) begin
                    line_d  = '0;
                    state_d = ACTIVE;
                end else begin
                    line_d = line_q + 1'b1;
                end
            end
            ACTIVE: if (cnt_q == LAST_ACT) state_d = HBLANK;
            HBLANK: if (eol) begin
                cnt_d = '0;
                if (line_q == LAST_VACT) begin
                    line_d = '0;
                    if (V_FRONT == 0) frame_done = 1'b1;
                    else              state_d    = VFRONT;
                end else begin
                    line_d  = line_q + 1'b1;
                    state_d = ACTIVE;
                end
            end
            VFRONT: if (eol) begin
                cnt_d = '0;
                if (line_q == LAST_VFRT) frame_done = 1'b1;
                else                     line_d     = line_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
        // A frame always runs to completion; enable only decides what follows.
        if (frame_done) begin
            line_d = '0;
            if (enable) begin
                state_d = VSYNC;
                fs_d    = 1'b1;
            end else begin
                state_d = IDLE;
            end
        end
    end

    // Holding buffer, byte selection and next values of the registered outputs.
    always_comb begin
        idx_q       = cnt_q[1:0];
        idx_d       = cnt_d[1:0];
        accept      = s.s_valid && s_ready_q;
        word_free   = (state_q == ACTIVE) && (idx_q == 2'd3) && !skip_q;
        buf_d       = buf_q;
        buf_valid_d = buf_valid_q;
        if (accept) begin
            buf_d       = s.s_data;
            buf_valid_d = 1'b1;
        end else if (word_free) begin
            buf_valid_d = 1'b0;
        end
        // An empty buffer at byte 0 turns the whole 4-byte slot into zeros.
        word_start = (state_d == ACTIVE) && (idx_d == 2'd0);
        skip_d     = 1'b0;
        if (state_d == ACTIVE) skip_d = word_start ? !buf_valid_d : skip_q;
        ur_d    = ur_q | (word_start & !buf_valid_d);
        vsync_d = (state_d == VSYNC);
        href_d  = (state_d == ACTIVE);
        data_d  = 8'h00;
        if (href_d && !skip_d) begin
            unique case (idx_d)
                2'd0: data_d = buf_d[31:24];
                2'd1: data_d = buf_d[23:16];
                2'd2: data_d = buf_d[15:8];
                2'd3: data_d = buf_d[7:0];
            endcase
        end
        // During a zero-filled slot the idx-3 refill path stays closed so a
        // word prefetched inside the slot is not overwritten.
        s_ready_d = (state_d != IDLE) &&
                    (!buf_valid_d || ((state_d == ACTIVE) && (idx_d == 2'd3) && !skip_d));
    end

    // State, counters, buffer flags and all registered outputs.
    always_ff @(posedge camera_pclk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            line_q      <= '0;
            buf_valid_q <= 1'b0;
            skip_q      <= 1'b0;
            vsync_q     <= 1'b0;
            href_q      <= 1'b0;
            data_q      <= 8'h00;
            fs_q        <= 1'b0;
            ur_q        <= 1'b0;
            s_ready_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            line_q      <= line_d;
            buf_valid_q <= buf_valid_d;
            skip_q      <= skip_d;
            vsync_q     <= vsync_d;
            href_q      <= href_d;
            data_q      <= data_d;
            fs_q        <= fs_d;
            ur_q        <= ur_d;
            s_ready_q   <= s_ready_d;
        end
    end

    // Buffer data word.
    always_ff @(posedge camera_pclk) begin
        // NOTE: the data word has no reset; buf_valid_q gates every use of it,
        // so clearing the valid bit is what empties the buffer.
        buf_q <= buf_d;
    end

    assign s.s_ready    = s_ready_q;
    assign camera_vsync = vsync_q;
    assign camera_href  = href_q;
    assign camera_data  = data_q;
    assign frame_start  = fs_q;
    assign underrun     = ur_q;

endmodule
